// File: rtl/chip8_fb_scaler.sv
// CHIP-8 64x32 framebuffer to 640x480 pixel source: each framebuffer pixel is a
// SCALE x SCALE block; each framebuffer row is prefetched into a line buffer in blanking.
module chip8_fb_scaler #(
   parameter int          H_ACTIVE     = 640,
   parameter int          V_ACTIVE     = 480,
   parameter int          SCALE        = 10,
   parameter int          FB_W         = 64,
   parameter int          FB_H         = 32,
   parameter int          V_OFFSET     = 80,
   parameter logic [15:0] FG_COLOR     = 16'hFFFF,
   parameter logic [15:0] BG_COLOR     = 16'h0000,
   parameter logic [15:0] BORDER_COLOR = 16'h0010
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic [9:0]  pixel_hpos,
   input  logic [9:0]  pixel_vpos,
   output logic [15:0] pixel_data,
   output logic        fb_rd_en,
   output logic [7:0]  fb_rd_addr,
   input  logic [7:0]  fb_rd_data,
   output logic        frame_end
);

   localparam int BYTES = FB_W / 8;
   localparam int KW    = $clog2(BYTES);
   localparam int RW    = $clog2(FB_H);
   localparam int SW    = $clog2(SCALE);
   localparam int CW    = $clog2(FB_W);

   localparam logic [9:0]    H_MAX    = 10'(H_ACTIVE);
   localparam logic [9:0]    V_MAX    = 10'(V_ACTIVE);
   localparam logic [9:0]    H_LAST   = 10'(H_ACTIVE - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_ACTIVE - 1);
   localparam logic [9:0]    V_FIRST  = 10'(V_OFFSET);
   localparam logic [9:0]    V_END    = 10'(V_OFFSET + FB_H * SCALE);
   localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
   localparam logic [KW-1:0] K_LAST   = KW'(BYTES - 1);

   typedef enum logic [1:0] {IDLE, READ, LAST} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic [RW-1:0]   row;
   logic [SW-1:0]   sub_row;
   logic [SW-1:0]   sub_col;
   logic [CW-1:0]   col;
   logic [FB_W-1:0] line_buf;

   logic [CW-1:0] col_cur;
   logic [SW-1:0] sub_col_cur;
   logic [CW-1:0] bit_sel;
   logic [KW-1:0] cap_byte;
   logic [9:0]    next_line;
   logic          active, img_line, trig, first_n, in_img_n, row_edge, fetch;
   logic [RW-1:0] row_nxt;
   logic [SW-1:0] sub_row_nxt;

   function automatic logic [7:0] rd_addr(input logic [RW-1:0] r, input logic [KW-1:0] b);
      return 8'(r * BYTES + b);
   endfunction

   always_comb begin
      // Column counters restart at hpos 0, so their stored value only matters mid-line.
      col_cur     = (pixel_hpos == '0) ? '0 : col;
      sub_col_cur = (pixel_hpos == '0) ? '0 : sub_col;
      bit_sel     = CW'(FB_W - 1) - col_cur;
      active      = (pixel_hpos < H_MAX) && (pixel_vpos < V_MAX);
      img_line    = (pixel_vpos >= V_FIRST) && (pixel_vpos < V_END);
      trig        = (pixel_hpos == H_LAST) && (pixel_vpos < V_MAX);
      next_line   = (pixel_vpos == V_LAST) ? '0 : pixel_vpos + 10'd1;
      first_n     = (next_line == V_FIRST);
      in_img_n    = (next_line >= V_FIRST) && (next_line < V_END);
      row_edge    = (sub_row == SUB_LAST);
      fetch       = first_n || (in_img_n && row_edge);
      cap_byte    = (state == LAST) ? '0 : K_LAST - (k - 1'b1);
      row_nxt     = row;
      sub_row_nxt = sub_row;
      if (first_n) begin
         row_nxt     = '0;
         sub_row_nxt = '0;
      end else if (in_img_n) begin
         if (row_edge) begin
            row_nxt     = row + 1'b1;
            sub_row_nxt = '0;
         end else begin
            sub_row_nxt = sub_row + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         k          <= '0;
         row        <= '0;
         sub_row    <= '0;
         sub_col    <= '0;
         col        <= '0;
         line_buf   <= '0;
         pixel_data <= 16'h0000;
         fb_rd_en   <= 1'b0;
         fb_rd_addr <= '0;
         frame_end  <= 1'b0;
      end else begin
         if (sub_col_cur == SUB_LAST) begin
            sub_col <= '0;
            col     <= col_cur + 1'b1;
         end else begin
            sub_col <= sub_col_cur + 1'b1;
            col     <= col_cur;
         end

         if (!active || !img_line)
            pixel_data <= BORDER_COLOR;
         else
            pixel_data <= line_buf[bit_sel] ? FG_COLOR : BG_COLOR;

         frame_end <= trig && (pixel_vpos == V_LAST);

         if (trig) begin
            row     <= row_nxt;
            sub_row <= sub_row_nxt;
         end

         // Read data lags the strobe by one clock, so each READ cycle stores the previous byte.
         case (state)
            IDLE: begin
               if (trig && fetch) begin
                  state      <= READ;
                  k          <= '0;
                  fb_rd_en   <= 1'b1;
                  fb_rd_addr <= rd_addr(row_nxt, '0);
               end
            end
            READ: begin
               if (k != '0)
                  line_buf[{cap_byte, 3'b000} +: 8] <= fb_rd_data;
               if (k == K_LAST) begin
                  state    <= LAST;
                  fb_rd_en <= 1'b0;
               end else begin
                  k          <= k + 1'b1;
                  fb_rd_addr <= rd_addr(row, k + 1'b1);
               end
            end
            LAST: begin
               line_buf[{cap_byte, 3'b000} +: 8] <= fb_rd_data;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
